issue_fu_array: RTL

- Parametrised issue/execute stage that replaces the fixed 2-ALU + 1-memory issue block.
- Takes up to NUM_ALU+1 instructions per cycle from the reservation stations.
  - Channels 0..NUM_ALU-1 are ALU channels, each with ALU_LAT pipeline stages.
  - Channel NUM_ALU is a load/store channel with a request/grant/response memory handshake.
- Sits between the reservation stations and the complete/ROB stage.
- Drives the complete bus and the operand-forwarding bus, and supports pipeline flush.

---
 rtl/issue_fu_array.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/issue_fu_array.sv
// Issue/execute stage: NUM_ALU pipelined ALU channels plus one load/store channel
// driving a request/grant/response memory port, the complete bus and the forwarding bus.
module issue_fu_array #(
    parameter int NUM_ALU = 2,
    parameter int ALU_LAT = 1,
    parameter int DATA_W  = 32,
    parameter int PREG_W  = 6,
    parameter int ROB_W   = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_flush,
    input  logic [NUM_ALU:0]                  i_valid,
    input  logic [3*NUM_ALU-1:0]              i_aluop,
    input  logic [(NUM_ALU+1)*DATA_W-1:0]     i_src0,
    input  logic [(NUM_ALU+1)*DATA_W-1:0]     i_src1,
    input  logic [(NUM_ALU+1)*DATA_W-1:0]     i_imm,
    input  logic [NUM_ALU:0]                  i_alusrc,
    input  logic [NUM_ALU:0]                  i_memwrite,
    input  logic [NUM_ALU:0]                  i_regwrite,
    input  logic [(NUM_ALU+1)*PREG_W-1:0]     i_pdst,
    input  logic [(NUM_ALU+1)*ROB_W-1:0]      i_rob,
    output logic [NUM_ALU:0]                  o_fu_ready,
    output logic                              o_mem_req,
    output logic                              o_mem_we,
    output logic [DATA_W-1:0]                 o_mem_addr,
    output logic [DATA_W-1:0]                 o_mem_wdata,
    input  logic                              i_mem_gnt,
    input  logic                              i_mem_rvalid,
    input  logic [DATA_W-1:0]                 i_mem_rdata,
    output logic [NUM_ALU:0]                  o_cmp_valid,
    output logic [(NUM_ALU+1)*ROB_W-1:0]      o_cmp_rob,
    output logic [NUM_ALU:0]                  o_cmp_regwrite,
    output logic [NUM_ALU:0]                  o_cmp_memwrite,
    output logic [(NUM_ALU+1)*DATA_W-1:0]     o_cmp_data,
    output logic [NUM_ALU:0]                  o_fwd_valid,
    output logic [(NUM_ALU+1)*PREG_W-1:0]     o_fwd_pdst,
    output logic [(NUM_ALU+1)*DATA_W-1:0]     o_fwd_data
);

    localparam int L = NUM_ALU;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} lsu_state_t;

    function automatic logic [DATA_W-1:0] alu_f(input logic [2:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = '0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a + b;
            3'b010: r = a | b;
            3'b011: r = a ^ b;
            3'b100: r = a - b;
            3'b101: r = a << b[4:0];
            3'b110: r = a >> b[4:0];
            default: r = $signed(a) >>> b[4:0];
        endcase
        return r;
    endfunction

    // Channels only accept from the cycle after reset is released.
    logic alive_q;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) alive_q <= 1'b0;
        else          alive_q <= 1'b1;
    end

    for (genvar k = 0; k < NUM_ALU; k++) begin : g_alu
        logic [ALU_LAT-1:0]             st_v, st_rw, st_mw;
        logic [ALU_LAT-1:0][DATA_W-1:0] st_d;
        logic [ALU_LAT-1:0][PREG_W-1:0] st_p;
        logic [ALU_LAT-1:0][ROB_W-1:0]  st_r;
        logic [DATA_W-1:0]              op1;
        logic                           acc;

        assign op1 = i_alusrc[k] ? i_imm[k*DATA_W +: DATA_W] : i_src1[k*DATA_W +: DATA_W];
        assign acc = i_valid[k] && alive_q && !i_flush;

        always_ff @(posedge i_clk) begin
            // NOTE: datapath registers are reset as well so the output buses never carry X.
            if (!i_rst_n) begin
                st_v  <= '0;
                st_rw <= '0;
                st_mw <= '0;
                st_d  <= '0;
                st_p  <= '0;
                st_r  <= '0;
            end else begin
                st_v[0] <= acc;
                if (acc) begin
                    st_d[0]  <= alu_f(i_aluop[k*3 +: 3], i_src0[k*DATA_W +: DATA_W], op1);
                    st_p[0]  <= i_pdst[k*PREG_W +: PREG_W];
                    st_r[0]  <= i_rob[k*ROB_W +: ROB_W];
                    st_rw[0] <= i_regwrite[k];
                    st_mw[0] <= i_memwrite[k];
                end
                for (int s = 1; s < ALU_LAT; s++) begin
                    st_v[s]  <= st_v[s-1] && !i_flush;
                    st_d[s]  <= st_d[s-1];
                    st_p[s]  <= st_p[s-1];
                    st_r[s]  <= st_r[s-1];
                    st_rw[s] <= st_rw[s-1];
                    st_mw[s] <= st_mw[s-1];
                end
            end
        end

        assign o_fu_ready[k]                    = alive_q;
        assign o_cmp_valid[k]                   = st_v[ALU_LAT-1];
        assign o_cmp_rob[k*ROB_W +: ROB_W]      = st_r[ALU_LAT-1];
        assign o_cmp_regwrite[k]                = st_rw[ALU_LAT-1];
        assign o_cmp_memwrite[k]                = st_mw[ALU_LAT-1];
        assign o_cmp_data[k*DATA_W +: DATA_W]   = st_d[ALU_LAT-1];
        assign o_fwd_valid[k]                   = st_v[ALU_LAT-1] && st_rw[ALU_LAT-1];
        assign o_fwd_pdst[k*PREG_W +: PREG_W]   = st_p[ALU_LAT-1];
        assign o_fwd_data[k*DATA_W +: DATA_W]   = st_d[ALU_LAT-1];
    end

    lsu_state_t        state;
    logic [DATA_W-1:0] lsu_addr, lsu_wdata, lsu_data;
    logic              lsu_we, lsu_rw;
    logic [PREG_W-1:0] lsu_pdst;
    logic [ROB_W-1:0]  lsu_rob;
    logic              lsu_acc;

    assign o_fu_ready[L] = alive_q && (state == S_IDLE);
    assign lsu_acc       = i_valid[L] && o_fu_ready[L] && !i_flush;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            lsu_addr  <= '0;
            lsu_wdata <= '0;
            lsu_data  <= '0;
            lsu_we    <= 1'b0;
            lsu_rw    <= 1'b0;
            lsu_pdst  <= '0;
            lsu_rob   <= '0;
        end else begin
            case (state)
                S_IDLE: if (lsu_acc) begin
                    lsu_addr  <= i_src0[L*DATA_W +: DATA_W] + i_imm[L*DATA_W +: DATA_W];
                    lsu_wdata <= i_src1[L*DATA_W +: DATA_W];
                    lsu_data  <= '0;
                    lsu_we    <= i_memwrite[L];
                    lsu_rw    <= i_regwrite[L];
                    lsu_pdst  <= i_pdst[L*PREG_W +: PREG_W];
                    lsu_rob   <= i_rob[L*ROB_W +: ROB_W];
                    state     <= S_REQ;
                end
                // A load granted under flush still has a response on its way.
                S_REQ: begin
                    if (i_mem_gnt) begin
                        if (i_flush) state <= lsu_we ? S_IDLE : S_DRAIN;
                        else         state <= lsu_we ? S_DONE : S_WAIT;
                    end else if (i_flush) begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (i_flush) begin
                        state <= i_mem_rvalid ? S_IDLE : S_DRAIN;
                    end else if (i_mem_rvalid) begin
                        lsu_data <= i_mem_rdata;
                        state    <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_DRAIN: if (i_mem_rvalid) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_mem_req   = (state == S_REQ);
    assign o_mem_we    = (state == S_REQ) && lsu_we;
    assign o_mem_addr  = lsu_addr;
    assign o_mem_wdata = lsu_wdata;

    assign o_cmp_valid[L]                  = (state == S_DONE);
    assign o_cmp_rob[L*ROB_W +: ROB_W]     = lsu_rob;
    assign o_cmp_regwrite[L]               = lsu_rw;
    assign o_cmp_memwrite[L]               = lsu_we;
    assign o_cmp_data[L*DATA_W +: DATA_W]  = lsu_data;
    assign o_fwd_valid[L]                  = (state == S_DONE) && !lsu_we && lsu_rw;
    assign o_fwd_pdst[L*PREG_W +: PREG_W]  = lsu_pdst;
    assign o_fwd_data[L*DATA_W +: DATA_W]  = lsu_data;

endmodule
